dual_ram_ctrl: RTL and testbench
================================

# dual_ram_ctrl

Parametrised dual-port word RAM with a request/grant/response handshake on both ports. It is the successor to the instruction/data scratch RAM in the memory subsystem. Port A is a read-only fetch port and port B is a read/write load-store port with per-byte strobes. Both ports have a registered one-cycle read latency and error responses for misaligned or out-of-range accesses. A built-in clear engine zeroes the whole array on request.

## Interface
Parameters:
- DATA_W, 32, data width in bits; a multiple of 8, at least 16
- DEPTH, 1024, number of words; a power of two
- ADDR_W, 32, byte-address width of both ports

Ports:
- clk  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- a_req_i  in  1  port A read request
- a_addr_i  in  ADDR_W  port A byte address
- a_gnt_o  out  1  port A request accepted this cycle
- a_rvalid_o  out  1  port A response valid
- a_rdata_o  out  DATA_W  port A read data
- a_err_o  out  1  port A error response, qualified by a_rvalid_o
- b_req_i  in  1  port B request
- b_we_i  in  1  port B write (1) or read (0)
- b_be_i  in  DATA_W/8  port B byte enables, used on writes only
- b_addr_i  in  ADDR_W  port B byte address
- b_wdata_i  in  DATA_W  port B write data
- b_gnt_o  out  1  port B request accepted this cycle
- b_rvalid_o  out  1  port B response valid, for reads and writes
- b_rdata_o  out  DATA_W  port B read data; 0 for writes
- b_err_o  out  1  port B error response, qualified by b_rvalid_o
- clear_i  in  1  start zeroing the array (level sampled in IDLE)
- clear_busy_o  out  1  clear engine active
- clear_done_o  out  1  one-cycle pulse when the clear completes

## Operation
- Word index is the byte address shifted right by log2(DATA_W/8); the unused low bits must be 0.
- Error conditions:
  - nonzero low address bits, or word index >= DEPTH, is an error access
  - an error access is granted normally, performs no write, returns rdata 0 and err 1
- Grant:
  - x_gnt_o = x_req_i & (state == IDLE) & !clear_i, combinational
  - both ports are granted in the same cycle whenever possible
  - a requester keeps req and its payload stable until granted
- Reads: the word is captured on the grant edge.
- Writes:
  - on the grant edge, byte i of the word is written with b_wdata_i byte i wherever b_be_i[i] = 1
  - b_be_i = 0 is legal: no change, normal response
- Port A reading the same word that port B writes in the same cycle: behaviour is set by the Configuration macro.
- Clear state machine, states IDLE and CLEAR:
  - IDLE -> CLEAR when clear_i = 1; the counter loads 0
  - in CLEAR, word[counter] <= 0 and counter increments every cycle; both gnt outputs are held at 0
  - at counter = DEPTH-1, the last word is written and the next state is IDLE
  - clear_done_o pulses 1 in the first IDLE cycle; clear_busy_o = (state == CLEAR)
  - clear_i is ignored while in CLEAR
- Responses for requests granted before CLEAR is entered are still delivered in the cycle after their grant.

## Timing
- Reset values:
  - all outputs 0 (gnt outputs are 0 because the state is IDLE and there are no requests)
  - state IDLE, counter 0
  - array contents are not reset
- Read/write latency is 1: x_rvalid_o = 1 exactly in the cycle after x_gnt_o = 1, with rdata/err valid in that same cycle.
- Throughput is one access per port per cycle, with back-to-back grants allowed.
- Data outputs are held (not zeroed) when rvalid = 0.
- A clear takes exactly DEPTH cycles with clear_busy_o = 1, then one clear_done_o cycle. Requests arriving during the clear are granted in the clear_done_o cycle.
- Reset asserted mid-operation:
  - state returns to IDLE immediately and pending responses are dropped (rvalid = 0)
  - a partially completed clear leaves the array partly zeroed; no clear_done_o is issued

## Configuration
- DUAL_RAM_WR_FWD_EN defined:
  - a same-cycle port A read of the word port B writes returns the post-write word
  - enabled bytes come from b_wdata_i, the remaining bytes from the array
- DUAL_RAM_WR_FWD_EN undefined: port A returns the pre-write (old) word.
- Port B behaviour is identical in both builds.

## Test plan
- Full write, then read: B writes 0xDEADBEEF to 0x40 with be=0xF; the next cycle B reads 0x40 and A reads 0x40 -> both return 0xDEADBEEF with err=0, one cycle after grant.
- Byte strobes: word 0x10 holds 0x11223344; B writes 0xAABBCCDD with be=0x5 -> a subsequent read returns 0x11BB33DD.
- Errors:
  - A reads 0x41 (misaligned) -> rvalid=1, err=1, rdata=0
  - B writes to byte address 4*DEPTH -> err=1 and the array is unchanged
- Same-cycle collision: word 0x20 holds 0x0; B writes 0x12345678 (be=0xF) while A reads 0x20 -> A returns 0x12345678 with the macro defined, 0x0 without.
- Clear with DEPTH=16:
  - preload all words with 0xFFFFFFFF, pulse clear_i -> busy for 16 cycles, gnt=0 throughout, done pulses on cycle 17
  - all subsequent reads return 0
- Reset mid-clear: assert rstn_i=0 at clear cycle 5 -> all outputs 0 and state IDLE; no clear_done_o; words 0-4 read back 0 and word 5 onward keep their old values.

Source files
------------

// File: rtl/dual_ram_ctrl.sv
// Dual-port word RAM: port A read-only fetch, port B byte-strobed load/store, built-in clear engine.
// Optional same-cycle B-to-A write forwarding is enabled by defining DUAL_RAM_WR_FWD_EN.
module dual_ram_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rstn_i,
  input  logic                a_req_i,
  input  logic [ADDR_W-1:0]   a_addr_i,
  output logic                a_gnt_o,
  output logic                a_rvalid_o,
  output logic [DATA_W-1:0]   a_rdata_o,
  output logic                a_err_o,
  input  logic                b_req_i,
  input  logic                b_we_i,
  input  logic [DATA_W/8-1:0] b_be_i,
  input  logic [ADDR_W-1:0]   b_addr_i,
  input  logic [DATA_W-1:0]   b_wdata_i,
  output logic                b_gnt_o,
  output logic                b_rvalid_o,
  output logic [DATA_W-1:0]   b_rdata_o,
  output logic                b_err_o,
  input  logic                clear_i,
  output logic                clear_busy_o,
  output logic                clear_done_o
);

  // state | meaning
  // IDLE  | serving port requests, watching clear_i
  // CLEAR | zeroing word[r_cnt] each cycle, all grants blocked

  localparam int NB    = DATA_W / 8;
  localparam int BSH   = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_done, w_done_nxt;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_a_rvalid, r_a_err;
  logic [DATA_W-1:0] r_a_rdata;
  logic              r_b_rvalid, r_b_err;
  logic [DATA_W-1:0] r_b_rdata;

  logic [ADDR_W-1:0] w_a_word, w_b_word;
  logic [IDX_W-1:0]  w_a_idx, w_b_idx;
  logic              w_a_err, w_b_err;
  logic              w_gnt_ok, w_b_wr;
  logic [DATA_W-1:0] w_a_rd;

  // Address decode: misaligned or beyond the array is an error access
  assign w_a_word = a_addr_i >> BSH;
  assign w_b_word = b_addr_i >> BSH;
  assign w_a_idx  = w_a_word[IDX_W-1:0];
  assign w_b_idx  = w_b_word[IDX_W-1:0];
  assign w_a_err  = (a_addr_i[BSH-1:0] != '0) || (w_a_word >= ADDR_W'(DEPTH));
  assign w_b_err  = (b_addr_i[BSH-1:0] != '0) || (w_b_word >= ADDR_W'(DEPTH));

  assign w_gnt_ok = (r_state == IDLE) && !clear_i;
  assign a_gnt_o  = a_req_i & w_gnt_ok;
  assign b_gnt_o  = b_req_i & w_gnt_ok;
  assign w_b_wr   = b_gnt_o & b_we_i & ~w_b_err;

`ifdef DUAL_RAM_WR_FWD_EN
  always_comb begin
    w_a_rd = r_mem[w_a_idx];
    if (w_b_wr && (w_b_idx == w_a_idx)) begin
      for (int i = 0; i < NB; i++) begin
        if (b_be_i[i]) w_a_rd[i*8 +: 8] = b_wdata_i[i*8 +: 8];
      end
    end
  end
`else
  assign w_a_rd = r_mem[w_a_idx];
`endif

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (clear_i) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        w_cnt_nxt = r_cnt + IDX_W'(1);
        if (r_cnt == IDX_W'(DEPTH - 1)) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign clear_busy_o = (r_state == CLEAR);
  assign clear_done_o = r_done;

  // Array has no reset; the clear engine and port B never write in the same cycle
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_b_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (b_be_i[i]) r_mem[w_b_idx][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
      end
    end
  end

  // Response registers: data and err hold their last value while rvalid is low
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_a_rvalid <= 1'b0;
      r_a_err    <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rvalid <= 1'b0;
      r_b_err    <= 1'b0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= a_gnt_o;
      r_b_rvalid <= b_gnt_o;
      if (a_gnt_o) begin
        r_a_err   <= w_a_err;
        r_a_rdata <= w_a_err ? '0 : w_a_rd;
      end
      if (b_gnt_o) begin
        r_b_err   <= w_b_err;
        r_b_rdata <= (w_b_err || b_we_i) ? '0 : r_mem[w_b_idx];
      end
    end
  end

  assign a_rvalid_o = r_a_rvalid;
  assign a_rdata_o  = r_a_rdata;
  assign a_err_o    = r_a_err;
  assign b_rvalid_o = r_b_rvalid;
  assign b_rdata_o  = r_b_rdata;
  assign b_err_o    = r_b_err;

endmodule

// File: tb/tb_dual_ram_ctrl.sv
// Randomized bench for dual_ram_ctrl (DEPTH=16) against an array-based reference model.
module tb_dual_ram_ctrl;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rstn_i;
  logic              a_req_i;
  logic [ADDR_W-1:0] a_addr_i;
  logic              a_gnt_o, a_rvalid_o, a_err_o;
  logic [DATA_W-1:0] a_rdata_o;
  logic              b_req_i, b_we_i;
  logic [3:0]        b_be_i;
  logic [ADDR_W-1:0] b_addr_i;
  logic [DATA_W-1:0] b_wdata_i;
  logic              b_gnt_o, b_rvalid_o, b_err_o;
  logic [DATA_W-1:0] b_rdata_o;
  logic              clear_i, clear_busy_o, clear_done_o;

  dual_ram_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn_i(rstn_i),
    .a_req_i(a_req_i), .a_addr_i(a_addr_i), .a_gnt_o(a_gnt_o),
    .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o), .a_err_o(a_err_o),
    .b_req_i(b_req_i), .b_we_i(b_we_i), .b_be_i(b_be_i), .b_addr_i(b_addr_i),
    .b_wdata_i(b_wdata_i), .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o),
    .b_rdata_o(b_rdata_o), .b_err_o(b_err_o),
    .clear_i(clear_i), .clear_busy_o(clear_busy_o), .clear_done_o(clear_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] rnd_addr();
    int r;
    logic [31:0] w;
    r = $urandom_range(0, 9);
    w = 32'($urandom_range(0, DEPTH - 1));
    if (r == 0) return (w << 2) | 32'($urandom_range(1, 3));
    if (r == 1) return (32'(DEPTH) + 32'($urandom_range(0, 1000))) << 2;
    return w << 2;
  endfunction

  // One cycle: drive, check grant, clock, check responses, update model
  task automatic xfer(input bit areq, input logic [31:0] aaddr, input bit breq, input bit bwe,
                      input logic [3:0] bbe, input logic [31:0] baddr, input logic [31:0] bwd);
    logic [31:0] ea, eb, wmask;
    int ai, bi;
    bit aerr, berr, bwr;
    a_req_i = areq; a_addr_i = aaddr;
    b_req_i = breq; b_we_i = bwe; b_be_i = bbe; b_addr_i = baddr; b_wdata_i = bwd;
    aerr  = addr_bad(aaddr);
    berr  = addr_bad(baddr);
    ai    = aerr ? 0 : int'(aaddr >> 2);
    bi    = berr ? 0 : int'(baddr >> 2);
    bwr   = breq && bwe && !berr;
    wmask = bwr ? be_mask(bbe) : 32'h0;
    ea    = aerr ? 32'h0 : mdl[ai];
    if (areq && !aerr && bwr && ai == bi) begin
`ifdef DUAL_RAM_WR_FWD_EN
      ea = (mdl[ai] & ~wmask) | (bwd & wmask);
`endif
    end
    eb = (berr || bwe) ? 32'h0 : mdl[bi];
    #1;
    chk("a_gnt", a_gnt_o, areq);
    chk("b_gnt", b_gnt_o, breq);
    @(posedge clk); #1;
    if (bwr) mdl[bi] = (mdl[bi] & ~wmask) | (bwd & wmask);
    chk("a_rvalid", a_rvalid_o, areq);
    if (areq) begin
      chk("a_err", a_err_o, aerr);
      chk("a_rdata", a_rdata_o, ea);
      last_a = ea;
    end else begin
      chk("a_hold", a_rdata_o, last_a);
    end
    chk("b_rvalid", b_rvalid_o, breq);
    if (breq) begin
      chk("b_err", b_err_o, berr);
      chk("b_rdata", b_rdata_o, eb);
      last_b = eb;
    end else begin
      chk("b_hold", b_rdata_o, last_b);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_gnt"}, a_gnt_o, 0);
    chk({tag, "_a_rvalid"}, a_rvalid_o, 0);
    chk({tag, "_a_rdata"}, a_rdata_o, 0);
    chk({tag, "_a_err"}, a_err_o, 0);
    chk({tag, "_b_gnt"}, b_gnt_o, 0);
    chk({tag, "_b_rvalid"}, b_rvalid_o, 0);
    chk({tag, "_b_rdata"}, b_rdata_o, 0);
    chk({tag, "_b_err"}, b_err_o, 0);
    chk({tag, "_busy"}, clear_busy_o, 0);
    chk({tag, "_done"}, clear_done_o, 0);
  endtask

  task automatic idle_inputs();
    a_req_i = 0; a_addr_i = 0; b_req_i = 0; b_we_i = 0; b_be_i = 0;
    b_addr_i = 0; b_wdata_i = 0; clear_i = 0;
  endtask

  initial begin
    int cycles;
    logic [31:0] old0;
    rstn_i = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst");
    rstn_i = 1'b1;

    for (int i = 0; i < DEPTH; i++) xfer(0, 0, 1, 1, 4'hF, 32'(i * 4), $urandom);

    // Full write then read from both ports (last word)
    xfer(0, 0, 1, 1, 4'hF, 32'h3C, 32'hDEADBEEF);
    xfer(1, 32'h3C, 1, 0, 4'h0, 32'h3C, 0);
    chk("tp_full_a", a_rdata_o, 32'hDEADBEEF);
    chk("tp_full_b", b_rdata_o, 32'hDEADBEEF);
    chk("tp_full_err", {a_err_o, b_err_o}, 0);

    // Byte strobes
    xfer(0, 0, 1, 1, 4'hF, 32'h10, 32'h11223344);
    xfer(0, 0, 1, 1, 4'h5, 32'h10, 32'hAABBCCDD);
    xfer(0, 0, 1, 0, 4'h0, 32'h10, 0);
    chk("tp_strobe", b_rdata_o, 32'h11BB33DD);
    xfer(0, 0, 1, 1, 4'h0, 32'h10, 32'hFFFFFFFF);
    xfer(1, 32'h10, 0, 0, 0, 0, 0);
    chk("tp_be0", a_rdata_o, 32'h11BB33DD);

    // Error accesses
    xfer(1, 32'h41, 0, 0, 0, 0, 0);
    chk("tp_mis_err", {a_rvalid_o, a_err_o}, 2'b11);
    chk("tp_mis_data", a_rdata_o, 0);
    old0 = mdl[0];
    xfer(0, 0, 1, 1, 4'hF, 32'(4 * DEPTH), 32'hCAFEF00D);
    chk("tp_oor_err", b_err_o, 1);
    xfer(1, 32'h0, 0, 0, 0, 0, 0);
    chk("tp_oor_keep", a_rdata_o, old0);

    // Same-cycle collision
    xfer(0, 0, 1, 1, 4'hF, 32'h20, 32'h0);
    xfer(1, 32'h20, 1, 1, 4'hF, 32'h20, 32'h12345678);
`ifdef DUAL_RAM_WR_FWD_EN
    chk("tp_collide", a_rdata_o, 32'h12345678);
`else
    chk("tp_collide", a_rdata_o, 32'h0);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] aa, ba;
      aa = rnd_addr();
      ba = ($urandom_range(0, 3) == 0) ? aa : rnd_addr();
      xfer(1'($urandom_range(0, 1)), aa, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), ba, $urandom);
    end

    // Clear with requests pending throughout
    for (int i = 0; i < DEPTH; i++) xfer(0, 0, 1, 1, 4'hF, 32'(i * 4), 32'hFFFFFFFF);
    clear_i = 1; a_req_i = 1; a_addr_i = 0; b_req_i = 1; b_we_i = 0; b_addr_i = 0;
    #1;
    chk("clr_start_gnt", {a_gnt_o, b_gnt_o}, 0);
    @(posedge clk); #1;
    clear_i = 0;
    cycles = 0;
    while (clear_busy_o && cycles < 100) begin
      chk("clr_gnt", {a_gnt_o, b_gnt_o}, 0);
      chk("clr_done_early", clear_done_o, 0);
      cycles++;
      @(posedge clk); #1;
    end
    chk("clr_cycles", cycles, DEPTH);
    chk("clr_done", clear_done_o, 1);
    for (int i = 0; i < DEPTH; i++) mdl[i] = 0;
    xfer(1, 0, 1, 0, 0, 0, 0);
    chk("clr_done_pulse", clear_done_o, 0);
    for (int i = 0; i < DEPTH; i++) begin
      xfer(1, 32'(i * 4), 1, 0, 0, 32'(((i + 5) % DEPTH) * 4), 0);
      chk("clr_zero", a_rdata_o, 0);
    end

    // Reset in the middle of a clear
    for (int i = 0; i < DEPTH; i++) xfer(0, 0, 1, 1, 4'hF, 32'(i * 4), 32'hA5A50000 | 32'(i));
    idle_inputs();
    clear_i = 1;
    @(posedge clk); #1;
    clear_i = 0;
    repeat (5) @(posedge clk);
    #1;
    rstn_i = 0;
    #1;
    chk_all_zero("mid_rst");
    @(posedge clk); #1;
    rstn_i = 1;
    last_a = 0; last_b = 0;
    for (int i = 0; i < 5; i++) mdl[i] = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(posedge clk); #1;
      chk("mid_no_done", {clear_busy_o, clear_done_o}, 0);
    end
    for (int i = 0; i < DEPTH; i++) xfer(1, 32'(i * 4), 1, 0, 0, 32'(i * 4), 0);
    xfer(1, 32'h14, 0, 0, 0, 0, 0);
    chk("mid_word5", a_rdata_o, 32'hA5A50005);
    xfer(1, 32'h10, 0, 0, 0, 0, 0);
    chk("mid_word4", a_rdata_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
